// File: rtl/pir_motion_ctrl.sv
// pir_motion_ctrl: multi-channel PIR motion controller.
// Each channel synchronises its raw PIR line, debounces it, and drives an LED
// with a retriggerable hold time. Qualified motion produces a one-cycle event
// pulse, and a saturating counter tracks events across all channels.
// Optional feature macro: PIR_BLANKING_EN. When it is defined, hold expiry
// enters a BLANK period during which the channel ignores its input.

// Per-channel synchroniser + qualify/hold FSM. Registered outputs, next-state
// values also exported so the top can register the shared status in step.
module pir_lane #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000
`ifdef PIR_BLANKING_EN
  ,
  parameter int BLANK_CYCLES    = 500
`endif
) (
  input  logic hwclk,
  input  logic rst_n,
  input  logic enable,
  input  logic pir,
  output logic led,
  output logic evt,
  output logic led_d,
  output logic evt_d
);
  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef PIR_BLANKING_EN
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int TW = (HW > BW) ? HW : BW;
`else
  localparam int TW = HW;
`endif

`ifdef PIR_BLANKING_EN
  typedef enum logic [2:0] {ST_IDLE, ST_QUALIFY, ST_ACTIVE, ST_HOLD, ST_BLANK} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_QUALIFY, ST_ACTIVE, ST_HOLD} state_t;
`endif

  logic [1:0]    sync_q;
  logic          s;
  state_t        st_q, st_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  // hold and blank never overlap, so one down-counter serves both
  logic [TW-1:0] tmr_q, tmr_d;

  assign s = sync_q[1];

  // next-state decode; disable overrides everything and drops to IDLE
  always_comb begin
    st_d   = st_q;
    qcnt_d = qcnt_q;
    tmr_d  = tmr_q;
    evt_d  = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (s) begin
          st_d   = ST_QUALIFY;
          qcnt_d = QW'(1);
        end
      end
      ST_QUALIFY: begin
        if (!s) begin
          st_d   = ST_IDLE;
          qcnt_d = '0;
        end else if (qcnt_q == QW'(DEBOUNCE_CYCLES)) begin
          st_d   = ST_ACTIVE;
          qcnt_d = '0;
          evt_d  = 1'b1;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      ST_ACTIVE: begin
        if (!s) begin
          st_d  = ST_HOLD;
          tmr_d = TW'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (s) begin
          st_d = ST_ACTIVE;
        end else if (tmr_q == '0) begin
`ifdef PIR_BLANKING_EN
          st_d  = ST_BLANK;
          tmr_d = TW'(BLANK_CYCLES - 1);
`else
          st_d  = ST_IDLE;
`endif
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
`ifdef PIR_BLANKING_EN
      ST_BLANK: begin
        if (tmr_q == '0) st_d = ST_IDLE;
        else             tmr_d = tmr_q - TW'(1);
      end
`endif
      default: st_d = ST_IDLE;
    endcase
    if (!enable) begin
      st_d   = ST_IDLE;
      qcnt_d = '0;
      tmr_d  = '0;
      evt_d  = 1'b0;
    end
  end

  assign led_d = (st_d == ST_ACTIVE) || (st_d == ST_HOLD);

  // state, counters and registered outputs; synchroniser runs even when disabled
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      sync_q <= '0;
      st_q   <= ST_IDLE;
      qcnt_q <= '0;
      tmr_q  <= '0;
      led    <= 1'b0;
      evt    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pir};
      st_q   <= st_d;
      qcnt_q <= qcnt_d;
      tmr_q  <= tmr_d;
      led    <= led_d;
      evt    <= evt_d;
    end
  end
endmodule

module pir_motion_ctrl #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int CNT_W           = 8,
  parameter int BLANK_CYCLES    = 500
) (
  input  logic             hwclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_CH-1:0]  pir_in,
  output logic [N_CH-1:0]  led_out,
  output logic [N_CH-1:0]  motion_evt,
  output logic             any_motion,
  output logic [CNT_W-1:0] evt_count
);
  localparam int SW = CNT_W + 5;
  localparam logic [SW-1:0] CNT_MAX = {5'b0, {CNT_W{1'b1}}};

  logic [N_CH-1:0]  led_d, evt_d;
  logic [4:0]       pop;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cnt_d;

  // out-of-range configurations select this empty block; nothing depends on it
  if (N_CH < 1 || N_CH > 16 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 ||
      BLANK_CYCLES < 1) begin : g_param_range_violation
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    pir_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
`ifdef PIR_BLANKING_EN
      ,
      .BLANK_CYCLES    (BLANK_CYCLES)
`endif
    ) u_lane (
      .hwclk  (hwclk),
      .rst_n  (rst_n),
      .enable (enable),
      .pir    (pir_in[i]),
      .led    (led_out[i]),
      .evt    (motion_evt[i]),
      .led_d  (led_d[i]),
      .evt_d  (evt_d[i])
    );
  end

  // popcount of this cycle's events, added with clamp at all-ones
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) pop = pop + 5'(evt_d[i]);
    sum   = SW'(evt_count) + SW'(pop);
    cnt_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // shared status registers, updated on the same edge as the lane outputs
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      any_motion <= 1'b0;
      evt_count  <= '0;
    end else begin
      any_motion <= |led_d;
      evt_count  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pir_motion_ctrl.sv
// Directed bench for pir_motion_ctrl: a per-cycle vector table for reset,
// first qualification and glitch rejection, then hand-written sequences for
// hold/retrigger, enable, counter saturation, blanking and mid-run reset.
module tb_pir_motion_ctrl;
  localparam int N_CH = 4, DEB = 3, HOLD = 8, CNT_W = 4, BLANK = 5;
`ifdef PIR_BLANKING_EN
  localparam int RISE = 20;   // hold expiry at 11, 5 blank cycles, 4 to requalify
`else
  localparam int RISE = 15;   // hold expiry at 11, requalify straight away
`endif

  logic             hwclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [N_CH-1:0]  pir_in = '0;
  logic [N_CH-1:0]  led_out, motion_evt;
  logic             any_motion;
  logic [CNT_W-1:0] evt_count;

  int n_pass = 0;
  int n_total = 0;

  pir_motion_ctrl #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .CNT_W(CNT_W), .BLANK_CYCLES(BLANK)
  ) dut (
    .hwclk(hwclk), .rst_n(rst_n), .enable(enable), .pir_in(pir_in),
    .led_out(led_out), .motion_evt(motion_evt), .any_motion(any_motion),
    .evt_count(evt_count)
  );

  always #10 hwclk = ~hwclk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] pir;
    logic [3:0] led;
    logic [3:0] evt;
    logic       any;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mkv(logic r, logic e, logic [3:0] p, logic [3:0] l,
                               logic [3:0] ev, logic a, logic [3:0] c);
    vec_t v;
    v.rst_n = r; v.en = e; v.pir = p; v.led = l; v.evt = ev; v.any = a; v.cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] l, input logic [3:0] ev,
                         input logic a, input logic [3:0] c);
    check({tag, " led_out"},    32'(led_out),    32'(l));
    check({tag, " motion_evt"}, 32'(motion_evt), 32'(ev));
    check({tag, " any_motion"}, 32'(any_motion), 32'(a));
    check({tag, " evt_count"},  32'(evt_count),  32'(c));
  endtask

  // apply inputs, take one rising edge, settle just past it
  task automatic step(input logic r, input logic e, input logic [3:0] p);
    rst_n = r; enable = e; pir_in = p;
    @(posedge hwclk);
    #1;
  endtask

  // disable one edge, re-enable with all inputs already high: 4 edges to requalify
  task automatic toggle_round(input string tag, input logic [3:0] cnt_before,
                              input logic [3:0] cnt_after);
    step(1, 0, 4'hF);
    chk_all({tag, " off"}, 4'h0, 4'h0, 1'b0, cnt_before);
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 4'hF);
      check({tag, " qualifying led"}, 32'(led_out), 32'h0);
    end
    step(1, 1, 4'hF);
    chk_all({tag, " event"}, 4'hF, 4'hF, 1'b1, cnt_after);
  endtask

  initial begin
    // reset with inputs high, then ch0 qualifies, then a 2-cycle glitch on ch1
    for (int i = 0; i < 3; i++) tbl[i] = mkv(0, 1, 4'hF, 4'h0, 4'h0, 0, 4'd0);
    for (int i = 3; i < 8; i++) tbl[i] = mkv(1, 1, 4'h1, 4'h0, 4'h0, 0, 4'd0);
    tbl[8]  = mkv(1, 1, 4'h1, 4'h1, 4'h1, 1, 4'd1);
    tbl[9]  = mkv(1, 1, 4'h1, 4'h1, 4'h0, 1, 4'd1);
    tbl[10] = mkv(1, 1, 4'h3, 4'h1, 4'h0, 1, 4'd1);
    tbl[11] = mkv(1, 1, 4'h3, 4'h1, 4'h0, 1, 4'd1);
    for (int i = 12; i < 17; i++) tbl[i] = mkv(1, 1, 4'h1, 4'h1, 4'h0, 1, 4'd1);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].pir);
      chk_all($sformatf("vec%0d", i), tbl[i].led, tbl[i].evt, tbl[i].any, tbl[i].cnt);
    end

    // hold then retrigger on ch0: led never drops, no second event
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, (i <= 5) ? 4'h0 : 4'h1);
      check($sformatf("retrig%0d led", i), 32'(led_out), 32'h1);
      check($sformatf("retrig%0d evt", i), 32'(motion_evt), 32'h0);
    end
    // release: led falls exactly HOLD+2 edges later
    for (int i = 1; i <= 11; i++) begin
      step(1, 1, 4'h0);
      check($sformatf("fall%0d led", i), 32'(led_out), (i < 11) ? 32'h1 : 32'h0);
      check($sformatf("fall%0d any", i), 32'(any_motion), (i < 11) ? 32'h1 : 32'h0);
    end
    check("count after hold", 32'(evt_count), 32'd1);

    // all four channels qualify on the same edge: count 1 -> 5
    for (int i = 1; i <= 5; i++) begin
      step(1, 1, 4'hF);
      check($sformatf("simul%0d led", i), 32'(led_out), 32'h0);
    end
    step(1, 1, 4'hF);
    chk_all("simul event", 4'hF, 4'hF, 1'b1, 4'd5);
    step(1, 1, 4'hF);
    chk_all("simul after", 4'hF, 4'h0, 1'b1, 4'd5);

    // release into HOLD, then disable mid-hold
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 4'h0);
      check($sformatf("prehold%0d led", i), 32'(led_out), 32'hF);
    end
    step(1, 0, 4'h0);
    chk_all("disable", 4'h0, 4'h0, 1'b0, 4'd5);
    step(1, 0, 4'hF);
    step(1, 0, 4'hF);
    chk_all("disabled primed", 4'h0, 4'h0, 1'b0, 4'd5);
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 4'hF);
      check($sformatf("reenable%0d led", i), 32'(led_out), 32'h0);
    end
    step(1, 1, 4'hF);
    chk_all("reenable event", 4'hF, 4'hF, 1'b1, 4'd9);
    step(1, 1, 4'hF);
    chk_all("reenable after", 4'hF, 4'h0, 1'b1, 4'd9);

    // climb to 13, then a 4-wide add clamps to 15 and stays there
    toggle_round("round13", 4'd9, 4'd13);
    toggle_round("round15", 4'd13, 4'd15);
    toggle_round("roundsat", 4'd15, 4'd15);

    // ch2 hold expiry with input reasserted during the (optional) blank window
    for (int i = 1; i <= 9; i++) begin
      step(1, 1, 4'hB);
      check($sformatf("blank%0d led", i), 32'(led_out), 32'hF);
    end
    for (int i = 10; i <= 21; i++) begin
      step(1, 1, 4'hF);
      check($sformatf("blank%0d led", i), 32'(led_out),
            (i >= 11 && i < RISE) ? 32'hB : 32'hF);
      check($sformatf("blank%0d evt", i), 32'(motion_evt),
            (i == RISE) ? 32'h4 : 32'h0);
    end

    // reset while everything is active
    step(0, 1, 4'hF);
    chk_all("midreset", 4'h0, 4'h0, 1'b0, 4'd0);
    step(1, 1, 4'hF);
    chk_all("postreset", 4'h0, 4'h0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pir_motion_ctrl.md
Name: pir_motion_ctrl

Overview:
Parametrised multi-channel PIR motion controller that replaces the single-input pir_in -> led_out path in top.
- Per channel: synchronises the raw PIR line, debounces it, and drives an LED with a retriggerable hold time.
- Emits a one-cycle pulse per qualified motion event.
- Keeps a global saturating event count for status readout.

Parameters:
N_CH, 4, number of PIR channels (1..16)
DEBOUNCE_CYCLES, 16, consecutive synchronised-high cycles required to qualify motion (>=1)
HOLD_CYCLES, 1000, cycles LED stays on after the synchronised input goes low (>=1)
CNT_W, 8, width of global event counter
BLANK_CYCLES, 500, post-hold blanking length (>=1; used only with PIR_BLANKING_EN)

Ports:
hwclk  input  1  system clock; all logic on its rising edge
rst_n  input  1  synchronous active-low reset
enable  input  1  global enable; low forces all channels idle
pir_in  input  N_CH  raw asynchronous PIR outputs, one bit per channel
led_out  output  N_CH  per-channel LED drive, registered
motion_evt  output  N_CH  one-cycle pulse per qualified event, registered
any_motion  output  1  OR of led_out, registered
evt_count  output  CNT_W  saturating count of qualified events, all channels

Behaviour:
- Clock/reset: one clock (hwclk); reset synchronous active-low (rst_n). rst_n low at an edge -> all outputs 0, all FSMs IDLE, all counters 0, synchronisers cleared.
- Reset mid-operation (any state) takes effect at the next edge; no event pulse is generated.
- Synchroniser: 2-FF per channel; FSM sees s = second stage only.
- Per-channel FSM states: IDLE, QUALIFY, ACTIVE, HOLD (plus BLANK when the macro is defined).
- IDLE: s=1 -> QUALIFY, qual_cnt=1.
- QUALIFY: s=0 -> IDLE (glitch rejected, no event). s=1 and qual_cnt<DEBOUNCE_CYCLES -> qual_cnt+1. s=1 and qual_cnt==DEBOUNCE_CYCLES -> ACTIVE; motion_evt pulses for exactly that cycle.
- ACTIVE: led on; s=0 -> HOLD, hold_cnt=HOLD_CYCLES-1.
- HOLD: led on. s=1 -> ACTIVE (retrigger; no new motion_evt, no count). hold_cnt==0 -> IDLE (or BLANK). Otherwise hold_cnt-1.
- LED timing: led_out=1 in ACTIVE/HOLD, 0 elsewhere.
  - Rise: exactly DEBOUNCE_CYCLES+2 edges after the first edge sampling pir_in high.
  - Fall: exactly HOLD_CYCLES+2 edges after the first edge sampling pir_in low, absent retrigger.
- any_motion: registered OR of next-state led values; changes in the same cycle as the corresponding led_out.
- evt_count arithmetic: each cycle add popcount(motion_evt next-state), CNT_W-bit, saturating at 2^CNT_W-1 (never wraps).
  - Simultaneous events on several channels in one cycle all count.
  - A partial add that would overflow clamps to max.
- enable=0 at an edge:
  - All FSMs -> IDLE; led_out, motion_evt, any_motion -> 0.
  - Synchronisers keep sampling; evt_count held.
  - On re-enable, a channel whose input is already high re-qualifies from QUALIFY, costing the full debounce.
- Channels are fully independent apart from evt_count and any_motion.

Optional Feature:
PIR_BLANKING_EN
- Defined: HOLD expiry -> BLANK with blank_cnt=BLANK_CYCLES-1.
  - In BLANK the input is ignored and led is off.
  - BLANK exits to IDLE when blank_cnt reaches 0.
  - enable=0 or reset -> IDLE immediately.
- Undefined: HOLD expiry -> IDLE directly; BLANK state and counter are absent; BLANK_CYCLES is unused.

Test Plan:
Bench settings: N_CH=4, DEBOUNCE_CYCLES=3, HOLD_CYCLES=8, CNT_W=4, BLANK_CYCLES=5, hwclk period 20 ns.

1. Reset: rst_n=0 for 3 edges with pir_in=4'hF -> all outputs 0, evt_count=0. Release rst_n, hold pir_in=4'h1 -> led_out[0] rises 5 edges after first sampling edge, motion_evt[0] high 1 cycle, evt_count=1.
2. Glitch: pir_in[1] high for 2 cycles then low -> led_out[1] never rises; motion_evt=0; evt_count unchanged.
3. Hold/retrigger: ch0 active; pir_in[0] low 5 cycles then high -> led stays high throughout, no second motion_evt. Then low -> led falls exactly 10 edges later.
4. Simultaneous events and saturation: preload evt_count=13, qualify ch0..ch3 on the same edge -> motion_evt=4'hF for one cycle, evt_count=15. A further event leaves it at 15.
5. Enable: enable=0 mid-HOLD -> led_out=0 and any_motion=0 next edge, evt_count held. enable=1 with pir_in high -> led returns after 3+1 debounce edges (synchronisers already primed) with a new motion_evt.
6. With PIR_BLANKING_EN: after ch2 hold expiry, pir_in[2]=1 during the 5 blank cycles -> no led or motion_evt until BLANK ends, then qualifies normally. Without the macro, the same stimulus re-qualifies immediately.
